// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the vending payout path (package vending_pkg).
// Coin codes, denomination values and the dispenser state encoding.
package vending_pkg;

   localparam int unsigned CENT_W    = 16;
   localparam int unsigned NUM_COINS = 6;

   typedef enum logic [2:0] {
      COIN_1   = 3'd0,
      COIN_5   = 3'd1,
      COIN_10  = 3'd2,
      COIN_25  = 3'd3,
      COIN_100 = 3'd4,
      COIN_500 = 3'd5
   } coin_e;

   localparam logic [CENT_W-1:0] COIN_VALUE [NUM_COINS] =
      '{16'd1, 16'd5, 16'd10, 16'd25, 16'd100, 16'd500};

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SELECT   = 3'd1,
      ST_FIRE     = 3'd2,
      ST_WAIT_ACK = 3'd3,
      ST_DONE     = 3'd4
   } state_e;

   // Face value of a coin code; unused codes map to zero.
   function automatic logic [CENT_W-1:0] coin_value(input coin_e c);
      case (c)
         COIN_1:   return 16'd1;
         COIN_5:   return 16'd5;
         COIN_10:  return 16'd10;
         COIN_25:  return 16'd25;
         COIN_100: return 16'd100;
         COIN_500: return 16'd500;
         default:  return 16'd0;
      endcase
   endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Payout bus between the vending FSM / hoppers and the change dispenser.
// O_COIN_TOTAL exists only when COIN_COUNT_EN is defined.
interface change_dispenser_if;
   import vending_pkg::*;

   logic [CENT_W-1:0]    I_CHANGE;
   logic                 I_CHANGE_VALID;
   logic [NUM_COINS-1:0] I_HOPPER_EMPTY;
   logic                 I_COIN_ACK;
   logic [2:0]           O_COIN_SEL;
   logic                 O_COIN_FIRE;
   logic                 O_BUSY;
   logic                 O_DONE;
   logic [CENT_W-1:0]    O_SHORT;
   logic                 O_ERROR;
   logic                 O_DROP;
`ifdef COIN_COUNT_EN
   logic [CENT_W-1:0]    O_COIN_TOTAL;
`endif

   modport master (
      output I_CHANGE, I_CHANGE_VALID, I_HOPPER_EMPTY, I_COIN_ACK,
      input  O_COIN_SEL, O_COIN_FIRE, O_BUSY, O_DONE, O_SHORT, O_ERROR, O_DROP
`ifdef COIN_COUNT_EN
      , input O_COIN_TOTAL
`endif
   );

   modport slave (
      input  I_CHANGE, I_CHANGE_VALID, I_HOPPER_EMPTY, I_COIN_ACK,
      output O_COIN_SEL, O_COIN_FIRE, O_BUSY, O_DONE, O_SHORT, O_ERROR, O_DROP
`ifdef COIN_COUNT_EN
      , output O_COIN_TOTAL
`endif
   );

endinterface

// File: rtl/change_dispenser_coin_pick.sv
// Greedy coin selector: largest denomination that fits the remainder and whose
// hopper is neither reported empty nor marked jammed in this payout.
module coin_pick
   import vending_pkg::*;
(
   input  logic [CENT_W-1:0]    remaining,
   input  logic [NUM_COINS-1:0] empty_mask,
   input  logic [NUM_COINS-1:0] jam_mask,
   output logic                 valid_c,
   output coin_e                code_c
);

   // Ascending scan so the last qualifying (largest) coin wins.
   always_comb begin
      valid_c = 1'b0;
      code_c  = COIN_1;
      for (int i = 0; i < NUM_COINS; i++) begin
         if ((COIN_VALUE[i] <= remaining) && !empty_mask[i] && !jam_mask[i]) begin
            valid_c = 1'b1;
            code_c  = coin_e'(3'(i));
         end
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// Change payout FSM: captures an amount, fires hoppers largest-coin-first,
// handles ack/timeout/empty, reports shortfall. Define COIN_COUNT_EN for O_COIN_TOTAL.
module change_dispenser
   import vending_pkg::*;
#(
   parameter int unsigned PULSE_CYCLES = 4,
   parameter int unsigned ACK_TIMEOUT  = 64
)(
   input logic              I_CLK,
   input logic              I_RESET,
   change_dispenser_if.slave bus
);

   localparam int unsigned PULSE_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   localparam int unsigned WAIT_W  = (ACK_TIMEOUT  > 1) ? $clog2(ACK_TIMEOUT)  : 1;

   state_e               state_q, state_d;
   logic [CENT_W-1:0]    rem_q, rem_d;
   logic [NUM_COINS-1:0] jam_q, jam_d;
   coin_e                sel_q, sel_d;
   logic [PULSE_W-1:0]   pulse_q, pulse_d;
   logic [WAIT_W-1:0]    wait_q, wait_d;
   logic                 ack_seen_q, ack_seen_d;
   logic [CENT_W-1:0]    short_q, short_d;
   logic                 error_d;
   logic                 credit_c;
   logic                 fire_q, busy_q, done_q, error_q, drop_q;
   logic                 pick_valid_c;
   coin_e                pick_code_c;

   coin_pick u_pick (
      .remaining  (rem_q),
      .empty_mask (bus.I_HOPPER_EMPTY),
      .jam_mask   (jam_q),
      .valid_c    (pick_valid_c),
      .code_c     (pick_code_c)
   );

   // Next-state and datapath updates.
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      jam_d      = jam_q;
      sel_d      = sel_q;
      pulse_d    = pulse_q;
      wait_d     = wait_q;
      ack_seen_d = ack_seen_q;
      short_d    = short_q;
      error_d    = 1'b0;
      credit_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.I_CHANGE_VALID) begin
               rem_d   = bus.I_CHANGE;
               jam_d   = '0;
               short_d = '0;
               state_d = ST_SELECT;
            end
         end
         ST_SELECT: begin
            if ((rem_q == '0) || !pick_valid_c) begin
               short_d = rem_q;
               error_d = (rem_q != '0);
               state_d = ST_DONE;
            end else begin
               sel_d      = pick_code_c;
               pulse_d    = '0;
               ack_seen_d = 1'b0;
               state_d    = ST_FIRE;
            end
         end
         ST_FIRE: begin
            if (bus.I_COIN_ACK) ack_seen_d = 1'b1;
            if (pulse_q == PULSE_W'(PULSE_CYCLES - 1)) begin
               wait_d  = '0;
               state_d = ST_WAIT_ACK;
            end else begin
               pulse_d = pulse_q + PULSE_W'(1);
            end
         end
         ST_WAIT_ACK: begin
            // An ack caught during the pulse is credited here, once.
            if (ack_seen_q || bus.I_COIN_ACK) begin
               credit_c = 1'b1;
               rem_d    = rem_q - coin_value(sel_q);
               state_d  = ST_SELECT;
            end else if (wait_q == WAIT_W'(ACK_TIMEOUT - 1)) begin
               jam_d[sel_q] = 1'b1;
               state_d      = ST_SELECT;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         state_q    <= ST_IDLE;
         rem_q      <= '0;
         jam_q      <= '0;
         sel_q      <= COIN_1;
         pulse_q    <= '0;
         wait_q     <= '0;
         ack_seen_q <= 1'b0;
         short_q    <= '0;
         fire_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         jam_q      <= jam_d;
         sel_q      <= sel_d;
         pulse_q    <= pulse_d;
         wait_q     <= wait_d;
         ack_seen_q <= ack_seen_d;
         short_q    <= short_d;
         fire_q     <= (state_d == ST_FIRE);
         busy_q     <= (state_d != ST_IDLE);
         done_q     <= (state_d == ST_DONE);
         error_q    <= error_d;
         drop_q     <= bus.I_CHANGE_VALID && (state_q != ST_IDLE);
      end
   end

   assign bus.O_COIN_SEL  = sel_q;
   assign bus.O_COIN_FIRE = fire_q;
   assign bus.O_BUSY      = busy_q;
   assign bus.O_DONE      = done_q;
   assign bus.O_SHORT     = short_q;
   assign bus.O_ERROR     = error_q;
   assign bus.O_DROP      = drop_q;

`ifdef COIN_COUNT_EN
   logic [CENT_W-1:0] total_q;

   // Saturating count of credited coins since reset.
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         total_q <= '0;
      end else if (credit_c && (total_q != 16'hFFFF)) begin
         total_q <= total_q + 16'd1;
      end
   end

   assign bus.O_COIN_TOTAL = total_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: vector table of payouts plus
// hand-written latency, overlap and reset sequences.
module tb_change_dispenser;
   import vending_pkg::*;

   localparam int unsigned PULSE = 4;
   localparam int unsigned TMO   = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   change_dispenser_if bus();

   change_dispenser #(.PULSE_CYCLES(PULSE), .ACK_TIMEOUT(TMO)) dut (
      .I_CLK   (clk),
      .I_RESET (rst),
      .bus     (bus)
   );

   // cnt = {n500, n100, n25, n10, n5, n1}; jam = coin code never acked (7 = none)
   typedef struct {
      logic [15:0]     change;
      logic [5:0]      empty;
      logic [2:0]      jam;
      logic [5:0][7:0] cnt;
      logic [15:0]     short_amt;
      logic            err;
   } vec_t;

   vec_t vecs [9];
   int   checks = 0;
   int   errors = 0;
   int   acks_sent = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Runs from the cycle after the strobe until O_DONE (bounded), acking each
   // non-jammed coin one cycle into WAIT_ACK; optionally injects a second strobe.
   task automatic watch(input logic [2:0] jam, input int inject_at,
                        output logic [5:0][7:0] cnt, output logic [15:0] sh,
                        output logic er, output bit done_seen, output bit drop_seen,
                        output int bad_pw, output int bad_order);
      bit         prev_fire = 1'b0;
      bit         arm = 1'b0;
      int         pw = 0;
      logic [2:0] last_sel = 3'd7;
      cnt = '0; sh = '0; er = 1'b0; done_seen = 1'b0; drop_seen = 1'b0;
      bad_pw = 0; bad_order = 0;
      for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
         bus.I_COIN_ACK = arm;
         if (arm) acks_sent++;
         arm = 1'b0;
         bus.I_CHANGE_VALID = (cyc == inject_at);
         if (cyc == inject_at) bus.I_CHANGE = 16'd50;
         if (bus.O_DROP) drop_seen = 1'b1;
         if (bus.O_COIN_FIRE && !prev_fire) begin
            cnt[bus.O_COIN_SEL] = cnt[bus.O_COIN_SEL] + 8'd1;
            if (last_sel != 3'd7 && bus.O_COIN_SEL > last_sel) bad_order++;
            last_sel = bus.O_COIN_SEL;
            pw = 1;
         end else if (bus.O_COIN_FIRE) begin
            pw++;
         end
         if (!bus.O_COIN_FIRE && prev_fire) begin
            if (pw != int'(PULSE)) bad_pw++;
            if (bus.O_COIN_SEL != jam) arm = 1'b1;
         end
         if (bus.O_DONE) begin
            done_seen = 1'b1;
            sh = bus.O_SHORT;
            er = bus.O_ERROR;
         end
         prev_fire = bus.O_COIN_FIRE;
         @(negedge clk);
      end
      bus.I_COIN_ACK = 1'b0;
      bus.I_CHANGE_VALID = 1'b0;
   endtask

   task automatic strobe(input logic [15:0] amt, input logic [5:0] empty);
      bus.I_CHANGE = amt;
      bus.I_HOPPER_EMPTY = empty;
      bus.I_CHANGE_VALID = 1'b1;
      @(negedge clk);
      bus.I_CHANGE_VALID = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      logic [5:0][7:0] cnt;
      logic [15:0]     sh;
      logic            er;
      bit              dn, dr;
      int              bpw, bord;
      strobe(v.change, v.empty);
      watch(v.jam, -1, cnt, sh, er, dn, dr, bpw, bord);
      chk({tag, "_done"},  64'(dn), 64'd1);
      chk({tag, "_coins"}, 64'(cnt), 64'(v.cnt));
      chk({tag, "_short"}, 64'(sh), 64'(v.short_amt));
      chk({tag, "_error"}, 64'(er), 64'(v.err));
      chk({tag, "_pulse"}, 64'(bpw), 64'd0);
      chk({tag, "_order"}, 64'(bord), 64'd0);
      chk({tag, "_idle"},  64'(bus.O_BUSY), 64'd0);
   endtask

   initial begin
      logic [5:0][7:0] cnt;
      logic [15:0]     sh;
      logic            er;
      bit              dn, dr;
      int              bpw, bord, extra;

      vecs[0] = '{16'd641,  6'b000000, 3'd7, {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 16'd0,  1'b0};
      vecs[1] = '{16'd200,  6'b010000, 3'd7, {8'd0, 8'd0, 8'd8, 8'd0, 8'd0, 8'd0}, 16'd0,  1'b0};
      vecs[2] = '{16'd100,  6'b000000, 3'd4, {8'd0, 8'd1, 8'd4, 8'd0, 8'd0, 8'd0}, 16'd0,  1'b0};
      vecs[3] = '{16'd7,    6'b000011, 3'd7, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 16'd7,  1'b1};
      vecs[4] = '{16'd0,    6'b000000, 3'd7, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 16'd0,  1'b0};
      vecs[5] = '{16'd1234, 6'b000000, 3'd7, {8'd2, 8'd2, 8'd1, 8'd0, 8'd1, 8'd4}, 16'd0,  1'b0};
      vecs[6] = '{16'd30,   6'b000100, 3'd7, {8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0}, 16'd0,  1'b0};
      vecs[7] = '{16'd30,   6'b111111, 3'd7, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 16'd30, 1'b1};
      vecs[8] = '{16'd13,   6'b000001, 3'd7, {8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0}, 16'd3,  1'b1};

      rst = 1'b1;
      bus.I_CHANGE = '0;
      bus.I_CHANGE_VALID = 1'b0;
      bus.I_HOPPER_EMPTY = '0;
      bus.I_COIN_ACK = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_fire",  64'(bus.O_COIN_FIRE), 64'd0);
      chk("rst_busy",  64'(bus.O_BUSY),      64'd0);
      chk("rst_done",  64'(bus.O_DONE),      64'd0);
      chk("rst_short", 64'(bus.O_SHORT),     64'd0);
      chk("rst_error", 64'(bus.O_ERROR),     64'd0);
      chk("rst_drop",  64'(bus.O_DROP),      64'd0);
      chk("rst_sel",   64'(bus.O_COIN_SEL),  64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
         @(negedge clk);
      end

      // Zero amount: O_DONE in cycle 2, busy drops in cycle 3.
      strobe(16'd0, 6'b000000);
      chk("lat0_busy_c1", 64'(bus.O_BUSY), 64'd1);
      chk("lat0_done_c1", 64'(bus.O_DONE), 64'd0);
      @(negedge clk);
      chk("lat0_done_c2", 64'(bus.O_DONE), 64'd1);
      chk("lat0_err_c2",  64'(bus.O_ERROR), 64'd0);
      @(negedge clk);
      chk("lat0_busy_c3", 64'(bus.O_BUSY), 64'd0);
      chk("lat0_done_c3", 64'(bus.O_DONE), 64'd0);
      @(negedge clk);

      // Shortfall without any fire: O_DONE in cycle 2 with short 7.
      strobe(16'd7, 6'b000011);
      chk("sf_fire_c1", 64'(bus.O_COIN_FIRE), 64'd0);
      @(negedge clk);
      chk("sf_done_c2",  64'(bus.O_DONE),  64'd1);
      chk("sf_short_c2", 64'(bus.O_SHORT), 64'd7);
      chk("sf_err_c2",   64'(bus.O_ERROR), 64'd1);
      chk("sf_fire_c2",  64'(bus.O_COIN_FIRE), 64'd0);
      repeat (2) @(negedge clk);

      // Second strobe mid-payout is dropped and never paid.
      strobe(16'd100, 6'b000000);
      watch(3'd7, 3, cnt, sh, er, dn, dr, bpw, bord);
      chk("ovl_done",  64'(dn),  64'd1);
      chk("ovl_drop",  64'(dr),  64'd1);
      chk("ovl_coins", 64'(cnt), 64'({8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0}));
      chk("ovl_short", 64'(sh),  64'd0);
      extra = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.O_COIN_FIRE || bus.O_BUSY || bus.O_DONE) extra++;
         @(negedge clk);
      end
      chk("ovl_no_second", 64'(extra), 64'd0);

      // Reset during FIRE of a 500c coin, then a fresh 5c payout.
      strobe(16'd500, 6'b000000);
      chk("rf_fire_c1", 64'(bus.O_COIN_FIRE), 64'd0);
      @(negedge clk);
      chk("rf_fire_c2", 64'(bus.O_COIN_FIRE), 64'd1);
      chk("rf_sel_c2",  64'(bus.O_COIN_SEL),  64'd5);
      rst = 1'b1;
      acks_sent = 0;
      @(negedge clk);
      chk("rf_fire_after", 64'(bus.O_COIN_FIRE), 64'd0);
      chk("rf_busy_after", 64'(bus.O_BUSY),      64'd0);
      rst = 1'b0;
      extra = 0;
      for (int c = 0; c < 10; c++) begin
         if (bus.O_DONE || bus.O_COIN_FIRE) extra++;
         @(negedge clk);
      end
      chk("rf_no_done", 64'(extra), 64'd0);
      run_vec('{16'd5, 6'b000000, 3'd7, {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0}, 16'd0, 1'b0}, "rf_pay5");

`ifdef COIN_COUNT_EN
      chk("coin_total", 64'(bus.O_COIN_TOTAL), 64'(acks_sent));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Downstream stage of the vending FSM. It captures the change amount when a transaction completes and drives the coin hoppers one coin at a time, using a greedy largest-coin-first order. It handles per-coin acknowledge, hopper-empty and timeout conditions, then reports completion and any undispensed shortfall.

Parameters:
PULSE_CYCLES, 4, cycles O_COIN_FIRE is held high per coin (hopper solenoid width).
ACK_TIMEOUT, 64, cycles to wait for I_COIN_ACK after the fire pulse ends before declaring that hopper jammed/empty.

Ports:
I_CLK  in  1  system clock.
I_RESET  in  1  synchronous, active-high reset.
I_CHANGE  in  16  change amount in cents (connected to the upstream O_CHANGE).
I_CHANGE_VALID  in  1  1-cycle strobe; I_CHANGE is valid this cycle.
I_HOPPER_EMPTY  in  6  per-denomination empty sensors. Bit 5..0 = 500,100,25,10,5,1 cents.
I_COIN_ACK  in  1  drop sensor; 1-cycle pulse per coin actually dispensed.
O_COIN_SEL  out  3  coin code being fired: 0=1c, 1=5c, 2=10c, 3=25c, 4=100c, 5=500c.
O_COIN_FIRE  out  1  hopper solenoid drive for O_COIN_SEL.
O_BUSY  out  1  high from capture until DONE.
O_DONE  out  1  1-cycle pulse at the end of a payout.
O_SHORT  out  16  undispensed remainder, valid with O_DONE and held until the next capture.
O_ERROR  out  1  high with O_DONE when O_SHORT != 0.
O_DROP  out  1  1-cycle pulse when I_CHANGE_VALID arrives while busy.

Behaviour:
- Reset values: all outputs 0. State IDLE. Remaining register 0. Jam mask 0.
- States: IDLE, SELECT, FIRE, WAIT_ACK, DONE.
- IDLE: on I_CHANGE_VALID, load remaining <= I_CHANGE, clear jam mask, set O_BUSY, go to SELECT.
- SELECT (1 cycle):
  - Pick the largest denomination d with value <= remaining, !I_HOPPER_EMPTY[d] and !jam[d].
  - If remaining == 0: go to DONE.
  - Else if no d qualifies: go to DONE (shortfall).
  - Else latch O_COIN_SEL=d and go to FIRE.
- FIRE: O_COIN_FIRE=1 for exactly PULSE_CYCLES cycles, then go to WAIT_ACK. O_COIN_SEL is stable through FIRE and WAIT_ACK.
- WAIT_ACK:
  - I_COIN_ACK: remaining <= remaining - value(d), go to SELECT.
  - No ack within ACK_TIMEOUT cycles: jam[d] <= 1, go to SELECT, remaining unchanged.
  - An ack arriving during FIRE counts as that coin's ack. At most one ack is credited per fire.
- DONE (1 cycle): O_DONE=1, O_SHORT=remaining, O_ERROR=(remaining!=0), O_BUSY=0 in the following cycle, go to IDLE.
- Latency: strobe at cycle 0 -> SELECT at cycle 1 -> O_COIN_FIRE first high at cycle 2. A zero amount gives O_DONE at cycle 2.
- Arithmetic: 16-bit unsigned. Subtraction never underflows because d is only chosen when value(d) <= remaining.
- I_CHANGE_VALID while O_BUSY: ignored, O_DROP pulses, payout continues unaffected.
- I_HOPPER_EMPTY is sampled only in SELECT. A hopper emptying mid-FIRE is handled by the timeout.
- Reset mid-payout: immediate return to IDLE, O_COIN_FIRE low on the next edge, remainder discarded, no O_DONE.
- Jam mask persists only for the current payout.

Optional Feature:
COIN_COUNT_EN
- Defined: adds output O_COIN_TOTAL [15:0], the count of acknowledged coins since reset. It increments on each credited ack, saturates at 16'hFFFF, and resets to 0.
- Undefined: port and counter absent. Behaviour is otherwise identical.

Decomposition:
- Package vending_pkg:
  - coin code typedef (3-bit enum COIN_1..COIN_500);
  - denomination value constant array (1,5,10,25,100,500);
  - NUM_COINS=6;
  - state typedef;
  - CENT_W=16.
- Sub-module coin_pick: combinational priority selector. Inputs are remaining, the empty mask and the jam mask. Outputs are a valid flag and the coin code. The FSM and timers stay in change_dispenser.

Test Plan:
- Exact greedy: I_CHANGE=641, no empties, ack 2 cycles after each fire -> coin sequence 500,100,25,10,5,1 → O_DONE, O_SHORT=0, O_ERROR=0.
- Empty hopper: I_CHANGE=200, I_HOPPER_EMPTY[4]=1 -> sequence 25×8 → O_SHORT=0.
- Timeout/jam: I_CHANGE=100, never ack 100c -> after PULSE_CYCLES+ACK_TIMEOUT the FSM falls to 25c×4 (acked) → O_SHORT=0, exactly one 100c fire.
- Shortfall: I_CHANGE=7, I_HOPPER_EMPTY=6'b000011 -> no fire, O_DONE at cycle 2, O_SHORT=7, O_ERROR=1.
- Overlap: second I_CHANGE_VALID (I_CHANGE=50) mid-payout of 100 -> O_DROP pulse, payout of 100 completes, the 50 is never paid.
- Reset mid-FIRE for I_CHANGE=500 -> O_COIN_FIRE low next cycle, O_BUSY=0, no O_DONE. A new strobe of 5 then pays one 5c coin.
